// File: rtl/sm83_pkg.sv
// Shared SM83 register-file types: register ids, step codes and reset constants.
package sm83_pkg;

  typedef logic [7:0]  reg8_t;
  typedef logic [15:0] reg16_t;

  typedef enum logic [3:0] {
    REG_B  = 4'd0,
    REG_C  = 4'd1,
    REG_D  = 4'd2,
    REG_E  = 4'd3,
    REG_H  = 4'd4,
    REG_L  = 4'd5,
    REG_A  = 4'd6,
    REG_F  = 4'd7,
    REG_BC = 4'd8,
    REG_DE = 4'd9,
    REG_HL = 4'd10,
    REG_AF = 4'd11,
    REG_SP = 4'd12,
    REG_PC = 4'd13
  } reg_id_t;

  // Code 2'b11 is not named and behaves as STEP_NONE wherever it is decoded.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_INC  = 2'b01,
    STEP_DEC  = 2'b10
  } step_t;

  localparam reg16_t BC_RST     = 16'h0013;
  localparam reg16_t DE_RST     = 16'h00D8;
  localparam reg16_t HL_RST     = 16'h014D;
  localparam reg16_t PC_RST_DEF = 16'h0100;
  localparam reg16_t SP_RST_DEF = 16'hFFFE;
  localparam reg16_t AF_RST_DEF = 16'h01B0;

endpackage

// File: rtl/sm83_step16.sv
// 16-bit increment / decrement / hold, wrapping modulo 2^16.
module sm83_step16
  import sm83_pkg::*;
(
  input  logic [15:0] value,
  input  step_t       step,
  output logic [15:0] result
);

  always_comb begin
    case (step)
      STEP_INC: result = value + 16'd1;
      STEP_DEC: result = value - 16'd1;
      default:  result = value;
    endcase
  end

endmodule

// File: rtl/sm83_regfile.sv
// SM83 register file: combinational multi-port reads, one explicit write,
// HL/SP steppers, PC increment and a masked flag update all in one cycle.
module sm83_regfile
  import sm83_pkg::*;
#(
  parameter int          NUM_RD_PORTS = 2,
  parameter logic [15:0] PC_RST       = PC_RST_DEF,
  parameter logic [15:0] SP_RST       = SP_RST_DEF,
  parameter logic [15:0] AF_RST       = AF_RST_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD_PORTS-1:0][3:0]  rd_sel,
  output logic [NUM_RD_PORTS-1:0][15:0] rd_data,
  input  logic                          wr_en,
  input  logic [3:0]                    wr_sel,
  input  logic [15:0]                   wr_data,
  input  logic [1:0]                    hl_step,
  input  logic [1:0]                    sp_step,
  input  logic                          pc_inc,
  input  logic [3:0]                    flag_we,
  input  logic [3:0]                    flag_in,
  output logic [3:0]                    flags,
  output logic                          err_illegal
);

  // F is held as its upper nibble only; the low nibble is constant zero.
  reg8_t       a, b, c, d, e, h, l;
  logic [3:0]  f;
  reg16_t      sp, pc;
  logic        err;

  reg8_t       a_n, b_n, c_n, d_n, e_n, h_n, l_n;
  logic [3:0]  f_n;
  reg16_t      sp_n, pc_n;
  logic        err_n;

  reg_id_t     wr_id;
  logic        hl_wr, sp_wr, pc_wr;
  step_t       hl_step_eff, sp_step_eff;
  reg16_t      hl_stepped, sp_stepped;

  assign wr_id = reg_id_t'(wr_sel);
  assign hl_wr = wr_en && (wr_id == REG_H || wr_id == REG_L || wr_id == REG_HL);
  assign sp_wr = wr_en && (wr_id == REG_SP);
  assign pc_wr = wr_en && (wr_id == REG_PC);

  assign hl_step_eff = hl_wr ? STEP_NONE : step_t'(hl_step);
  assign sp_step_eff = sp_wr ? STEP_NONE : step_t'(sp_step);

  sm83_step16 u_hl_step (
    .value  ({h, l}),
    .step   (hl_step_eff),
    .result (hl_stepped)
  );

  sm83_step16 u_sp_step (
    .value  (sp),
    .step   (sp_step_eff),
    .result (sp_stepped)
  );

  // Background updates first, then the explicit write overrides its target.
  always_comb begin
    a_n   = a;
    b_n   = b;
    c_n   = c;
    d_n   = d;
    e_n   = e;
    h_n   = hl_stepped[15:8];
    l_n   = hl_stepped[7:0];
    sp_n  = sp_stepped;
    pc_n  = (pc_inc && !pc_wr) ? pc + 16'd1 : pc;
    err_n = err;
    for (int i = 0; i < 4; i++) begin
      f_n[i] = flag_we[i] ? flag_in[i] : f[i];
    end
    if (wr_en) begin
      case (wr_id)
        REG_B:  b_n = wr_data[7:0];
        REG_C:  c_n = wr_data[7:0];
        REG_D:  d_n = wr_data[7:0];
        REG_E:  e_n = wr_data[7:0];
        REG_H:  h_n = wr_data[7:0];
        REG_L:  l_n = wr_data[7:0];
        REG_A:  a_n = wr_data[7:0];
        REG_F:  f_n = wr_data[7:4];
        REG_BC: {b_n, c_n} = wr_data;
        REG_DE: {d_n, e_n} = wr_data;
        REG_HL: {h_n, l_n} = wr_data;
        REG_AF: begin
          a_n = wr_data[15:8];
          f_n = wr_data[7:4];
        end
        REG_SP: sp_n = wr_data;
        REG_PC: pc_n = wr_data;
        default: err_n = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a   <= AF_RST[15:8];
      f   <= AF_RST[7:4];
      {b, c} <= BC_RST;
      {d, e} <= DE_RST;
      {h, l} <= HL_RST;
      sp  <= SP_RST;
      pc  <= PC_RST;
      err <= 1'b0;
    end else begin
      a   <= a_n;
      f   <= f_n;
      b   <= b_n;
      c   <= c_n;
      d   <= d_n;
      e   <= e_n;
      h   <= h_n;
      l   <= l_n;
      sp  <= sp_n;
      pc  <= pc_n;
      err <= err_n;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      case (reg_id_t'(rd_sel[p]))
        REG_B:   rd_data[p] = {8'h00, b};
        REG_C:   rd_data[p] = {8'h00, c};
        REG_D:   rd_data[p] = {8'h00, d};
        REG_E:   rd_data[p] = {8'h00, e};
        REG_H:   rd_data[p] = {8'h00, h};
        REG_L:   rd_data[p] = {8'h00, l};
        REG_A:   rd_data[p] = {8'h00, a};
        REG_F:   rd_data[p] = {8'h00, f, 4'h0};
        REG_BC:  rd_data[p] = {b, c};
        REG_DE:  rd_data[p] = {d, e};
        REG_HL:  rd_data[p] = {h, l};
        REG_AF:  rd_data[p] = {a, f, 4'h0};
        REG_SP:  rd_data[p] = sp;
        REG_PC:  rd_data[p] = pc;
        default: rd_data[p] = 16'h0000;
      endcase
    end
  end

  assign flags       = f;
  assign err_illegal = err;

endmodule

// File: tb/tb_sm83_regfile.sv
// Self-checking bench for sm83_regfile: directed boundary cases plus random
// traffic compared against an array-based model of the register file.
module tb_sm83_regfile;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0][3:0]   rd_sel;
  logic [1:0][15:0]  rd_data;
  logic              wr_en;
  logic [3:0]        wr_sel;
  logic [15:0]       wr_data;
  logic [1:0]        hl_step;
  logic [1:0]        sp_step;
  logic              pc_inc;
  logic [3:0]        flag_we;
  logic [3:0]        flag_in;
  logic [3:0]        flags;
  logic              err_illegal;

  int checks = 0;
  int errors = 0;

  // Model: m[0..7] = B,C,D,E,H,L,A,F as bytes; sp, pc and sticky error.
  logic [7:0]  m [0:7];
  logic [15:0] m_sp, m_pc;
  logic        m_err;

  always #5 clk = ~clk;

  sm83_regfile #(.NUM_RD_PORTS(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .hl_step     (hl_step),
    .sp_step     (sp_step),
    .pc_inc      (pc_inc),
    .flag_we     (flag_we),
    .flag_in     (flag_in),
    .flags       (flags),
    .err_illegal (err_illegal)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] id);
    int k;
    k = int'(id);
    if (k < 8)       return {8'h00, m[k]};
    else if (k < 12) return {m[(k - 8) * 2], m[(k - 8) * 2 + 1]};
    else if (k == 12) return m_sp;
    else if (k == 13) return m_pc;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m[0] = 8'h00; m[1] = 8'h13; m[2] = 8'h00; m[3] = 8'hD8;
    m[4] = 8'h01; m[5] = 8'h4D; m[6] = 8'h01; m[7] = 8'hB0;
    m_sp = 16'hFFFE; m_pc = 16'h0100; m_err = 1'b0;
  endtask

  task automatic model_clock();
    logic [15:0] hl;
    int          k;
    k = int'(wr_sel);
    if (!rst_n) begin
      model_reset();
      return;
    end
    hl = {m[4], m[5]};
    if (!(wr_en && (k == 4 || k == 5 || k == 10))) begin
      if (hl_step == 2'd1) hl = hl + 16'd1;
      else if (hl_step == 2'd2) hl = hl - 16'd1;
    end
    m[4] = hl[15:8];
    m[5] = hl[7:0];
    if (!(wr_en && k == 12)) begin
      if (sp_step == 2'd1) m_sp = m_sp + 16'd1;
      else if (sp_step == 2'd2) m_sp = m_sp - 16'd1;
    end
    if (pc_inc && !(wr_en && k == 13)) m_pc = m_pc + 16'd1;
    for (int i = 0; i < 4; i++)
      if (flag_we[i]) m[7][4 + i] = flag_in[i];
    if (wr_en) begin
      if (k < 8) m[k] = wr_data[7:0];
      else if (k < 12) begin
        m[(k - 8) * 2]     = wr_data[15:8];
        m[(k - 8) * 2 + 1] = wr_data[7:0];
      end
      else if (k == 12) m_sp = wr_data;
      else if (k == 13) m_pc = wr_data;
      else m_err = 1'b1;
      m[7][3:0] = 4'h0;
    end
  endtask

  task automatic check_outputs();
    check("rd0", rd_data[0], model_read(rd_sel[0]));
    check("rd1", rd_data[1], model_read(rd_sel[1]));
    check("flags", {12'h000, flags}, {12'h000, m[7][7:4]});
    check("err", {15'h0000, err_illegal}, {15'h0000, m_err});
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_sel = 4'd0; wr_data = 16'h0000;
    hl_step = 2'd0; sp_step = 2'd0; pc_inc = 1'b0;
    flag_we = 4'h0; flag_in = 4'h0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    tick();
    idle();
  endtask

  task automatic check_reg(input string tag, input logic [3:0] id, input logic [15:0] exp);
    rd_sel[0] = id;
    #1;
    check(tag, rd_data[0], exp);
  endtask

  logic [15:0] rst_tbl [0:13];

  initial begin
    rst_tbl = '{16'h0000, 16'h0013, 16'h0000, 16'h00D8, 16'h0001, 16'h004D,
                16'h0001, 16'h00B0, 16'h0013, 16'h00D8, 16'h014D, 16'h01B0,
                16'hFFFE, 16'h0100};
    idle();
    rd_sel = '0;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset image on both ports
    for (int id = 0; id < 14; id += 2) begin
      rd_sel[0] = 4'(id);
      rd_sel[1] = 4'(id + 1);
      #1;
      check("rst_p0", rd_data[0], rst_tbl[id]);
      check("rst_p1", rd_data[1], rst_tbl[id + 1]);
    end
    check("rst_flags", {12'h000, flags}, 16'h000B);
    tick();
    rd_sel[0] = 4'd14; rd_sel[1] = 4'd15;
    #1;
    check("undef14", rd_data[0], 16'h0000);
    check("undef15", rd_data[1], 16'h0000);

    // Wraparound of HL and SP
    wr(4'd10, 16'hFFFF);
    hl_step = 2'd1;
    tick();
    idle();
    check_reg("hl_wrap", 4'd10, 16'h0000);
    wr(4'd12, 16'h0000);
    sp_step = 2'd2;
    tick();
    idle();
    check_reg("sp_wrap", 4'd12, 16'hFFFF);

    // F low nibble forced to zero, then masked flag write
    wr(4'd11, 16'h12FF);
    check_reg("af_mask", 4'd11, 16'h12F0);
    flag_we = 4'b0001; flag_in = 4'b0000;
    tick();
    idle();
    check("flags_c", {12'h000, flags}, 16'h000E);

    // Explicit write suppresses HL step and PC increment
    wr_en = 1'b1; wr_sel = 4'd10; wr_data = 16'h4000; hl_step = 2'd2;
    tick();
    idle();
    check_reg("hl_wr_wins", 4'd10, 16'h4000);
    wr_en = 1'b1; wr_sel = 4'd13; wr_data = 16'h0200; pc_inc = 1'b1;
    tick();
    idle();
    check_reg("pc_wr_wins", 4'd13, 16'h0200);

    // Illegal write target: nothing changes, sticky error
    wr(4'd15, 16'h1234);
    check("err_set", {15'h0000, err_illegal}, 16'h0001);
    check_reg("hl_kept", 4'd10, 16'h4000);
    check_reg("af_kept", 4'd11, 16'h12E0);
    tick();
    tick();
    check("err_sticky", {15'h0000, err_illegal}, 16'h0001);

    // Reset beats a concurrent write and PC increment
    rst_n = 1'b0;
    wr_en = 1'b1; wr_sel = 4'd6; wr_data = 16'h0055; pc_inc = 1'b1;
    tick();
    idle();
    rst_n = 1'b1;
    check_reg("rst_a", 4'd6, 16'h0001);
    check_reg("rst_pc", 4'd13, 16'h0100);
    check("err_clear", {15'h0000, err_illegal}, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      wr_en     = ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0;
      wr_sel    = 4'($urandom_range(0, 15));
      wr_data   = 16'($urandom);
      hl_step   = 2'($urandom_range(0, 3));
      sp_step   = 2'($urandom_range(0, 3));
      pc_inc    = 1'($urandom_range(0, 1));
      flag_we   = 4'($urandom_range(0, 15));
      flag_in   = 4'($urandom_range(0, 15));
      rd_sel[0] = 4'($urandom_range(0, 15));
      rd_sel[1] = 4'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
